// File: rtl/median_disp_stream.sv
`default_nettype none
// ============================================================================
// median_disp_stream : streaming 3x3 median filter for disparity maps
// Revision: 1.0
// ============================================================================
module median_disp_stream #(
    parameter int WIDTH = 16,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int FW = $clog2(IMG_W + 1);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [FW-1:0] F_LAST = FW'(IMG_W);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d, cx_q, cx_d;
    logic [YW-1:0]   y_q, y_d, cy_q, cy_d;
    logic [FW-1:0]   fl_q, fl_d;
    logic            frame_mode_q;

    logic            adv, beat, produce, beat0;

    logic [WIDTH-1:0] lb0_q [IMG_W];
    logic [WIDTH-1:0] lb1_q [IMG_W];
    logic [WIDTH-1:0] lb0_rd, lb1_rd;
    logic [WIDTH-1:0] win_q [3][3];
    logic             win_v_q, win_byp_q, win_last_q;

    logic [WIDTH-1:0] s1_hi_q [3];
    logic [WIDTH-1:0] s1_md_q [3];
    logic [WIDTH-1:0] s1_lo_q [3];
    logic [WIDTH-1:0] s1_raw_q;
    logic             s1_v_q, s1_byp_q, s1_last_q;

    logic [WIDTH-1:0] s2_a_q, s2_b_q, s2_c_q, s2_raw_q;
    logic             s2_v_q, s2_byp_q, s2_last_q;

    logic [WIDTH-1:0] m_data_q;
    logic             m_valid_q, m_last_q;

    function automatic logic [WIDTH-1:0] max2(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [WIDTH-1:0] min2(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a > b) ? b : a;
    endfunction

    function automatic logic [WIDTH-1:0] max3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
        return max2(max2(a, b), c);
    endfunction

    function automatic logic [WIDTH-1:0] min3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [WIDTH-1:0] med3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    assign adv     = !m_valid_q || m_ready;
    assign s_ready = adv && (state_q != ST_FLUSH);
    // Flush steps are beats too; they push don't-care data to drain the window.
    assign beat    = adv && ((state_q == ST_FLUSH) || s_valid);
    assign produce = beat && (state_q != ST_FILL);
    assign beat0   = beat && (state_q == ST_FILL) && (x_q == '0) && (y_q == '0);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        fl_d    = fl_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        if (beat) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
            case (state_q)
                ST_FILL: begin
                    if ((x_q == '0) && (y_q == Y_ONE)) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if ((x_q == X_LAST) && (y_q == Y_LAST)) state_d = ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (fl_q == F_LAST) begin
                        state_d = ST_FILL;
                        fl_d    = '0;
                        x_d     = '0;
                        y_d     = '0;
                    end else begin
                        fl_d = fl_q + 1'b1;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
        if (produce) begin
            if (cx_q == X_LAST) begin
                cx_d = '0;
                cy_d = (cy_q == Y_LAST) ? '0 : cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FILL;
            x_q          <= '0;
            y_q          <= '0;
            fl_q         <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            frame_mode_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fl_q    <= fl_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            if (beat0) frame_mode_q <= mode;
        end
    end

    // lb0 holds the previous line, lb1 the line before it, indexed by column.
    assign lb0_rd = lb0_q[x_q];
    assign lb1_rd = lb1_q[x_q];

    always_ff @(posedge clk) begin
        if (beat) begin
            lb0_q[x_q] <= s_data;
            lb1_q[x_q] <= lb0_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
                s1_hi_q[r] <= '0;
                s1_md_q[r] <= '0;
                s1_lo_q[r] <= '0;
            end
            win_v_q    <= 1'b0;
            win_byp_q  <= 1'b0;
            win_last_q <= 1'b0;
            s1_raw_q   <= '0;
            s1_v_q     <= 1'b0;
            s1_byp_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_a_q     <= '0;
            s2_b_q     <= '0;
            s2_c_q     <= '0;
            s2_raw_q   <= '0;
            s2_v_q     <= 1'b0;
            s2_byp_q   <= 1'b0;
            s2_last_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
        end else if (adv) begin
            if (beat) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb1_rd;
                win_q[1][2] <= lb0_rd;
                win_q[2][2] <= s_data;
            end
            // Border centres see wrapped or stale columns, so they pass through raw.
            win_v_q    <= produce;
            win_byp_q  <= !frame_mode_q || (cx_q == '0) || (cx_q == X_LAST) ||
                          (cy_q == '0) || (cy_q == Y_LAST);
            win_last_q <= (cx_q == X_LAST) && (cy_q == Y_LAST);

            for (int r = 0; r < 3; r++) begin
                s1_hi_q[r] <= max3(win_q[r][0], win_q[r][1], win_q[r][2]);
                s1_md_q[r] <= med3(win_q[r][0], win_q[r][1], win_q[r][2]);
                s1_lo_q[r] <= min3(win_q[r][0], win_q[r][1], win_q[r][2]);
            end
            s1_raw_q  <= win_q[1][1];
            s1_v_q    <= win_v_q;
            s1_byp_q  <= win_byp_q;
            s1_last_q <= win_last_q;

            s2_a_q    <= min3(s1_hi_q[0], s1_hi_q[1], s1_hi_q[2]);
            s2_b_q    <= med3(s1_md_q[0], s1_md_q[1], s1_md_q[2]);
            s2_c_q    <= max3(s1_lo_q[0], s1_lo_q[1], s1_lo_q[2]);
            s2_raw_q  <= s1_raw_q;
            s2_v_q    <= s1_v_q;
            s2_byp_q  <= s1_byp_q;
            s2_last_q <= s1_last_q;

            m_valid_q <= s2_v_q;
            m_last_q  <= s2_v_q && s2_last_q;
            if (s2_v_q) m_data_q <= s2_byp_q ? s2_raw_q : med3(s2_a_q, s2_b_q, s2_c_q);
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;

endmodule
`default_nettype wire

// File: tb/tb_median_disp_stream.sv
`default_nettype none
// ============================================================================
// tb_median_disp_stream : scoreboard bench for the streaming 3x3 median filter
// Revision: 1.0
// ============================================================================
module tb_median_disp_stream;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;
    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          mode;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    exp_t          exp_q [$];
    logic [DW-1:0] img [N];
    int            n_chk = 0;
    int            n_bad = 0;
    int            n_out = 0;
    int            cyc = 0;
    int            first_v = -2;
    int            b9_cyc = 0;
    int            rdy_pct = 100;
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic          hold_l = 1'b0;

    median_disp_stream #(.WIDTH(DW), .IMG_W(W), .IMG_H(H)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: full sort of the 9 neighbours, raw pixel on borders or bypass.
    function automatic exp_t model(input int c, input logic fm);
        int            x = c % W;
        int            y = c / W;
        int            k = 0;
        logic [DW-1:0] v [9];
        logic [DW-1:0] t;
        exp_t          e;
        if (!fm || x == 0 || x == W - 1 || y == 0 || y == H - 1) begin
            e.d = img[c];
        end else begin
            for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++) begin
                    v[k] = img[(y + dy) * W + x + dx];
                    k++;
                end
            for (int i = 0; i < 9; i++)
                for (int j = 0; j < 8 - i; j++)
                    if (v[j] > v[j + 1]) begin
                        t = v[j]; v[j] = v[j + 1]; v[j + 1] = t;
                    end
            e.d = v[4];
        end
        e.l = (c == N - 1);
        return e;
    endfunction

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_data", m_data, hold_d);
                chk("hold_last", m_last, hold_l);
            end
            hold_pend = m_valid && !m_ready;
            hold_d    = m_data;
            hold_l    = m_last;
            if (m_valid && first_v == -1) first_v = cyc;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_out", m_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", m_data, e.d);
                    chk("out_last", m_last, e.l);
                    n_out++;
                end
            end
        end
    end

    task automatic drive_pixel(input logic [DW-1:0] d, input int gap, output int acc);
        int g = 0;
        while ($urandom_range(99) < gap) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (!s_ready && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (!s_ready) chk("s_ready_timeout", s_ready, 1'b1);
        acc = cyc + 1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic fm, input int gap, input int nbeats);
        int acc;
        for (int c = 0; c < N; c++) exp_q.push_back(model(c, fm));
        mode = fm;
        for (int i = 0; i < nbeats; i++) begin
            drive_pixel(img[i], gap, acc);
            if (i == 9) b9_cyc = acc;
            if (i == 0) mode = ~fm;
        end
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(posedge clk);
            g++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_m_last", m_last, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        mode    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 1'b1);

        // Constant frame with latency and count checks
        for (int i = 0; i < N; i++) img[i] = 16'd37;
        n_out   = 0;
        first_v = -1;
        send_frame(1'b1, 0, N);
        drain();
        chk("t1_count", n_out, N);
        chk("t1_latency", first_v - b9_cyc, 32'd3);

        // Interior impulse, then border impulse, back to back
        for (int i = 0; i < N; i++) img[i] = '0;
        img[2 * W + 3] = 16'd1000;
        send_frame(1'b1, 0, N);
        for (int i = 0; i < N; i++) img[i] = '0;
        img[0] = 16'd1000;
        send_frame(1'b1, 0, N);
        drain();

        // Ramp, unstalled then stalled
        for (int i = 0; i < N; i++) img[i] = DW'((i % W) + W * (i / W));
        send_frame(1'b1, 0, N);
        drain();
        rdy_pct = 50;
        send_frame(1'b1, 30, N);
        drain();

        // Random data through the sorting network under stalls
        for (int i = 0; i < N; i++) img[i] = DW'($urandom_range(65535));
        send_frame(1'b1, 25, N);
        drain();

        // Bypass with random data
        rdy_pct = 70;
        for (int i = 0; i < N; i++) img[i] = DW'($urandom_range(65535));
        send_frame(1'b0, 10, N);
        drain();

        // Abort a bypass frame with reset, then a clean constant frame
        rdy_pct = 100;
        for (int i = 0; i < N; i++) img[i] = DW'($urandom_range(1, 65535));
        send_frame(1'b0, 0, 20);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        chk("rst2_s_ready", s_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_out = 0;
        for (int i = 0; i < N; i++) img[i] = 16'd5;
        send_frame(1'b1, 0, N);
        drain();
        chk("t7_count", n_out, N);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
